// File: rtl/sdwr.sv
// sdwr: ICB slave that buffers one 512-byte sector and sends it as an SD 4-bit single-block
// write data phase with per-line CRC16, CRC status and busy wait. Macro SDWR_IRQ_EN builds the done IRQ.
module sdwr #(
  parameter int CLK_DIV      = 4,
  parameter int STAT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdwr_icb_cmd_valid,
  output logic        sdwr_icb_cmd_ready,
  input  logic [31:0] sdwr_icb_cmd_addr,
  input  logic        sdwr_icb_cmd_read,
  input  logic [31:0] sdwr_icb_cmd_wdata,
  input  logic [3:0]  sdwr_icb_cmd_wmask,
  output logic        sdwr_icb_rsp_valid,
  input  logic        sdwr_icb_rsp_ready,
  output logic        sdwr_icb_rsp_err,
  output logic [31:0] sdwr_icb_rsp_rdata,
  output logic        sd_clk_o,
  output logic [3:0]  sd_dat_o,
  output logic        sd_dat_oe,
  input  logic        sd_dat0_i,
  output logic        irq_sdwr_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0]   TO_LAST  = 11'(STAT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END, S_STAT, S_BUSY, S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   buf_mem [128];
  logic [7:0]    count;
  logic          busy, done, crc_ok, started;
  logic [2:0]    token;
  logic [DW-1:0] div_cnt;
  logic [10:0]   cnt;
  logic [15:0]   crc [4];

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  logic        cmd_fire, data_wr, start_req, full, data_ok, start_ok;
  logic        tick, rise, fall, done_evt;
  logic [31:0] cur_word, stat_word;
  logic [7:0]  cur_byte;
  logic [3:0]  cur_nib, crc_msb;
  logic        unused;

  assign sdwr_icb_cmd_ready = ~sdwr_icb_rsp_valid;
  assign cmd_fire  = sdwr_icb_cmd_valid & sdwr_icb_cmd_ready;
  assign data_wr   = cmd_fire & ~sdwr_icb_cmd_read & (sdwr_icb_cmd_addr[3:2] == 2'd0);
  assign start_req = cmd_fire & ~sdwr_icb_cmd_read & (sdwr_icb_cmd_addr[3:2] == 2'd1)
                   & sdwr_icb_cmd_wdata[0];
  assign full      = (count == 8'd128);
  assign data_ok   = data_wr & ~full & ~busy;
  assign start_ok  = start_req & ~busy & full;
  assign stat_word = {16'h0, count, 2'b00, crc_ok, token, done, busy};
  assign unused    = ^{sdwr_icb_cmd_addr[31:4], sdwr_icb_cmd_addr[1:0], sdwr_icb_cmd_wmask};

  // sd_clk edges: a tick toggles sd_clk; rise samples DAT0, fall advances the drive pattern.
  assign tick = (state != S_IDLE) && (state != S_DONE) && (div_cnt == DIV_LAST);
  assign rise = tick & ~sd_clk_o;
  assign fall = tick & sd_clk_o;

  assign cur_word = buf_mem[cnt[9:3]];
  assign cur_byte = cur_word[{cnt[2:1], 3'b000} +: 8];
  assign cur_nib  = cnt[0] ? cur_byte[3:0] : cur_byte[7:4];
  assign crc_msb  = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};

  assign done_evt = rise && (((state == S_BUSY) && sd_dat0_i) ||
                             ((state == S_STAT) && !started && sd_dat0_i && (cnt == TO_LAST)));

  // NOTE: the sector buffer has no reset; count gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (data_ok) buf_mem[count[6:0]] <= sdwr_icb_cmd_wdata;
  end

  // NOTE: all state here uses non-blocking assignments, so later assignments in the block
  // simply override earlier ones for the same edge (e.g. sd_clk forced low on DONE entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      sdwr_icb_rsp_valid <= 1'b0;
      sdwr_icb_rsp_err   <= 1'b0;
      sdwr_icb_rsp_rdata <= '0;
      sd_clk_o           <= 1'b0;
      sd_dat_o           <= '0;
      sd_dat_oe          <= 1'b0;
      count              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      token              <= '0;
      crc_ok             <= 1'b0;
      started            <= 1'b0;
      div_cnt            <= '0;
      cnt                <= '0;
      for (int i = 0; i < 4; i++) crc[i] <= '0;
    end else begin
      if (cmd_fire) begin
        sdwr_icb_rsp_valid <= 1'b1;
        sdwr_icb_rsp_err   <= (data_wr & (full | busy)) | (start_req & (busy | ~full));
        sdwr_icb_rsp_rdata <= (sdwr_icb_cmd_read && sdwr_icb_cmd_addr[3:2] == 2'd2) ? stat_word : '0;
      end else if (sdwr_icb_rsp_valid && sdwr_icb_rsp_ready) begin
        sdwr_icb_rsp_valid <= 1'b0;
      end

      if (data_ok) begin
        count <= count + 8'd1;
        done  <= 1'b0;
      end

      if (tick) begin
        div_cnt  <= '0;
        sd_clk_o <= ~sd_clk_o;
      end else if (state != S_IDLE && state != S_DONE) begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        S_IDLE: if (start_ok) begin
          state     <= S_PRE;
          busy      <= 1'b1;
          done      <= 1'b0;
          div_cnt   <= '0;
          sd_clk_o  <= 1'b0;
          sd_dat_oe <= 1'b1;
          sd_dat_o  <= 4'hF;
          cnt       <= '0;
          for (int i = 0; i < 4; i++) crc[i] <= '0;
        end
        S_PRE: if (fall) begin
          if (cnt == 11'd7) begin
            state    <= S_START;
            sd_dat_o <= 4'h0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        S_START: if (fall) begin
          state    <= S_DATA;
          sd_dat_o <= cur_nib;
          for (int i = 0; i < 4; i++) crc[i] <= crc16_step(crc[i], cur_nib[i]);
          cnt      <= 11'd1;
        end
        S_DATA: if (fall) begin
          if (cnt == 11'd1024) begin
            state    <= S_CRC;
            sd_dat_o <= crc_msb;
            for (int i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
            cnt      <= 11'd1;
          end else begin
            sd_dat_o <= cur_nib;
            for (int i = 0; i < 4; i++) crc[i] <= crc16_step(crc[i], cur_nib[i]);
            cnt      <= cnt + 11'd1;
          end
        end
        S_CRC: if (fall) begin
          if (cnt == 11'd16) begin
            state    <= S_END;
            sd_dat_o <= 4'hF;
          end else begin
            sd_dat_o <= crc_msb;
            for (int i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
            cnt      <= cnt + 11'd1;
          end
        end
        S_END: if (fall) begin
          state     <= S_STAT;
          sd_dat_oe <= 1'b0;
          sd_dat_o  <= 4'h0;
          cnt       <= '0;
          started   <= 1'b0;
        end
        S_STAT: if (rise) begin
          if (!started) begin
            if (!sd_dat0_i) begin
              started <= 1'b1;
              cnt     <= '0;
            end else if (cnt == TO_LAST) begin
              token <= 3'b111;
              crc_ok <= 1'b0;
            end else begin
              cnt <= cnt + 11'd1;
            end
          end else if (cnt == 11'd3) begin
            state  <= S_BUSY;
            crc_ok <= (token == 3'b010);
          end else begin
            token <= {token[1:0], sd_dat0_i};
            cnt   <= cnt + 11'd1;
          end
        end
        S_BUSY: ;
        S_DONE: begin
          state    <= S_IDLE;
          sd_clk_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (done_evt) begin
        state    <= S_DONE;
        done     <= 1'b1;
        busy     <= 1'b0;
        count    <= '0;
        sd_clk_o <= 1'b0;
      end
    end
  end

`ifdef SDWR_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= done_evt;
  end
  assign irq_sdwr_done = irq_q;
`else
  assign irq_sdwr_done = 1'b0;
`endif

endmodule
